inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter DEPTH, default 4: instruction buffer entries; SHALL be a power of two, 2 to 16.
REQ-003 CLOCK  input  1  sole clock; all state on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 MEM_REQ  output  1  read request to synchronous instruction memory.
REQ-006 MEM_ADDR  output  32  byte address of request; bits [1:0] always 0.
REQ-007 MEM_RDATA  input  32  read data, valid exactly one cycle after a MEM_REQ cycle.
REQ-008 INST  output  typePack::instruction_t  instruction at buffer head.
REQ-009 INST_PC  output  32  address of INST.
REQ-010 INST_VALID  output  1  buffer head holds a valid instruction.
REQ-011 INST_READY  input  1  core accepts head; transfer when INST_VALID && INST_READY.
REQ-012 REDIRECT  input  1  flush and restart fetch at REDIRECT_PC.
REQ-013 REDIRECT_PC  input  32  new fetch address; bits [1:0] ignored, treated as 0.
REQ-014 HALT  input  1  stop issuing new fetches.

Function
REQ-015 FSM states BOOT, RUN, HALTED; BOOT->RUN unconditionally after one cycle; RUN->HALTED when HALT=1 and REDIRECT=0; HALTED->RUN only on REDIRECT=1; REDIRECT from any state SHALL go to RUN.
REQ-016 MEM_REQ SHALL be 1 only in RUN, when HALT=0, REDIRECT=0, and buffer occupancy plus in-flight requests (0 or 1) is less than DEPTH after counting a same-cycle pop.
REQ-017 MEM_ADDR SHALL equal fetch PC; fetch PC SHALL advance by 4 on each issued request, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 Response data arriving the cycle after a request SHALL be pushed with its address; fetch-to-INST_VALID latency SHALL be 2 cycles from the MEM_REQ edge when the buffer is empty.
REQ-019 Buffer SHALL be FIFO; INST/INST_PC SHALL hold stable while INST_VALID=1 and INST_READY=0.
REQ-020 Simultaneous push and pop at full SHALL be legal; occupancy unchanged.
REQ-021 Sustained throughput with INST_READY=1 SHALL be one instruction per cycle.
REQ-022 REDIRECT=1 SHALL, on that edge, empty the buffer, discard any response due next cycle, and load fetch PC with {REDIRECT_PC[31:2],2'b00}; first new MEM_REQ SHALL occur the cycle after.
REQ-023 INST_VALID SHALL be 0 in the cycle after a REDIRECT edge; a handshake in the REDIRECT cycle itself still counts as consumed.
REQ-024 HALT SHALL not flush the buffer; already-issued responses SHALL still be pushed and drained.
REQ-025 REDIRECT and HALT both 1 SHALL apply REDIRECT (state RUN), no request that cycle.

Reset
REQ-026 While RESET=1: state BOOT, fetch PC = RESET_PC, buffer empty, in-flight cleared, MEM_REQ=0, INST_VALID=0, INST_PC=0, INST=0.
REQ-027 Reset asserted mid-operation SHALL immediately (asynchronously) clear outputs; a response arriving after reset deassertion for a pre-reset request SHALL be discarded.

Structure
REQ-028 typePack SHALL hold fetch_state_t (BOOT, RUN, HALTED) and INST_BYTES=4 alongside the existing instruction_t.
REQ-029 Buffer SHALL be sub-module fetch_fifo (DEPTH x {32-bit PC, instruction_t}, push/pop/count, async reset, flush input).

Verification
REQ-030 Reset release, INST_READY=1, memory returns addr^32'hA5A5_0000 -> MEM_ADDR 0,4,8,...; INST_PC 0 valid 2 cycles after first MEM_REQ, then one per cycle.
REQ-031 INST_READY=0 for 10 cycles, DEPTH=4 -> exactly 4 requests, INST_PC held at 0, INST_VALID=1, MEM_REQ=0 thereafter; INST_READY=1 resumes at addr 16 in order.
REQ-032 REDIRECT=1, REDIRECT_PC=32'h0000_1003 while request to 8 in flight -> data for 8 never appears; next MEM_ADDR 32'h0000_1000; next INST_PC 32'h0000_1000.
REQ-033 RESET_PC=32'hFFFF_FFF8 -> INST_PC FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-034 HALT=1 with 2 buffered plus 1 in flight -> no new MEM_REQ, 3 instructions drained, INST_VALID=0; REDIRECT to 32'h40 -> fetch resumes at 32'h40.
REQ-035 RESET pulsed mid-stream with request in flight -> outputs 0 immediately; post-reset first INST_PC = RESET_PC, stale data never delivered.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction fetch slice: instruction word, fetch FSM
// states and the instruction size in bytes.
package typePack;

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  localparam int INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between the fetch unit, the instruction memory and the core.
// master is the fetch unit side; slave is the memory/core side.
interface inst_fetch_if;
  import typePack::*;

  logic         MEM_REQ;
  logic [31:0]  MEM_ADDR;
  logic [31:0]  MEM_RDATA;
  instruction_t INST;
  logic [31:0]  INST_PC;
  logic         INST_VALID;
  logic         INST_READY;
  logic         REDIRECT;
  logic [31:0]  REDIRECT_PC;
  logic         HALT;

  modport master (
    output MEM_REQ, MEM_ADDR, INST, INST_PC, INST_VALID,
    input  MEM_RDATA, INST_READY, REDIRECT, REDIRECT_PC, HALT
  );

  modport slave (
    input  MEM_REQ, MEM_ADDR, INST, INST_PC, INST_VALID,
    output MEM_RDATA, INST_READY, REDIRECT, REDIRECT_PC, HALT
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, instruction}, FIFO order,
// with a synchronous flush that empties it in one edge.
module fetch_fifo
  import typePack::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   flush,
  input  logic                   push,
  input  logic [31:0]            push_pc,
  input  instruction_t           push_inst,
  input  logic                   pop,
  output logic [31:0]            head_pc,
  output instruction_t           head_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]  pc_mem   [DEPTH];
  instruction_t inst_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  // At full a push is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]   <= push_pc;
        inst_mem[wr_ptr] <= push_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues sequential reads to a one-cycle-latency
// memory, buffers responses in fetch_fifo and hands them to the core.
module inst_fetch
  import typePack::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic         CLOCK,
  input  logic         RESET,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic          inflight;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [CW:0]   demand;
  logic          pop;
  logic          mem_req;

  assign pop    = bus.INST_VALID && bus.INST_READY;
  assign demand = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  // A request is only issued when its response is guaranteed a buffer slot.
  assign mem_req = (state == RUN) && !bus.HALT && !bus.REDIRECT && (demand < DEPTH_W);

  assign bus.MEM_REQ    = mem_req;
  assign bus.MEM_ADDR   = fetch_pc;
  assign bus.INST_VALID = (count != '0);

  always_comb begin
    state_next = state;
    if (bus.REDIRECT) begin
      state_next = RUN;
    end else begin
      case (state)
        BOOT:    state_next = RUN;
        RUN:     state_next = bus.HALT ? HALTED : RUN;
        HALTED:  state_next = HALTED;
        default: state_next = BOOT;
      endcase
    end
  end

  // A redirect never coincides with a request, so inflight clears on it too.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= BOOT;
      fetch_pc    <= {RESET_PC[31:2], 2'b00};
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_next;
      inflight <= mem_req;
      if (mem_req) begin
        inflight_pc <= fetch_pc;
      end
      if (bus.REDIRECT) begin
        fetch_pc <= {bus.REDIRECT_PC[31:2], 2'b00};
      end else if (mem_req) begin
        fetch_pc <= fetch_pc + 32'(INST_BYTES);
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .flush     (bus.REDIRECT),
    .push      (inflight),
    .push_pc   (inflight_pc),
    .push_inst (bus.MEM_RDATA),
    .pop       (pop),
    .head_pc   (bus.INST_PC),
    .head_inst (bus.INST),
    .count     (count)
  );

endmodule
